// File: rtl/note_lane_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_lane_renderer_pkg
// Brief    : Shared colour codes, VGA screen limits, FSM state encoding and
//            the slot colour-priority helper for the note lane renderer.
// Revision : 1.0 - initial release
// ============================================================================
package note_lane_renderer_pkg;

    // 3-bit RGB colour codes understood by the VGA adapter
    localparam logic [2:0] c_col_black  = 3'b000;
    localparam logic [2:0] c_col_red    = 3'b100;
    localparam logic [2:0] c_col_yellow = 3'b110;
    localparam logic [2:0] c_col_green  = 3'b010;
    // Reserved for other drawers; the lane never emits it
    localparam logic [2:0] c_col_blue   = 3'b001;

    // Visible screen of the VGA adapter
    localparam int c_vga_width  = 160;
    localparam int c_vga_height = 120;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Hit highlight beats red, red beats yellow, empty slots are painted
    // black so the square left over from the previous frame is erased.
    function automatic logic [2:0] pick_colour(input logic red,
                                               input logic yellow,
                                               input logic hit_slot0);
        if (hit_slot0 && (red || yellow)) return c_col_green;
        if (red)                          return c_col_red;
        if (yellow)                       return c_col_yellow;
        return c_col_black;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_lane_renderer_square_scan.sv
`default_nettype none
// ============================================================================
// Module   : note_lane_renderer_square_scan
// Brief    : px/py raster counter for one SQ_SIZE x SQ_SIZE square, px fastest.
//            Flags the last pixel of the square.
// Revision : 1.0 - initial release
// ============================================================================
module note_lane_renderer_square_scan #(
    parameter int SQ_SIZE = 4,
    localparam int CW = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          clear,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py,
    output logic          last_pixel
);

    localparam logic [CW-1:0] c_max = CW'(SQ_SIZE - 1);

    // Raster counter: clear wins, otherwise step px and carry into py
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (enable) begin
            if (px == c_max) begin
                px <= '0;
                py <= (py == c_max) ? '0 : py + CW'(1);
            end else begin
                px <= px + CW'(1);
            end
        end
    end

    assign last_pixel = (px == c_max) && (py == c_max);

endmodule
`default_nettype wire

// File: rtl/note_lane_renderer.sv
`default_nettype none
// ============================================================================
// Module   : note_lane_renderer
// Brief    : On start, snapshots the red/yellow note lanes and paints every
//            slot square one pixel per cycle to the VGA adapter, with a
//            start/busy/done handshake and a green hit highlight on slot 0.
// Revision : 1.0 - initial release
// ============================================================================
module note_lane_renderer
    import note_lane_renderer_pkg::*;
#(
    parameter int NUM_SLOTS = 10,
    parameter int SQ_SIZE   = 4,
    parameter int X_ORIGIN  = 10,
    parameter int X_PITCH   = 10,
    parameter int Y_ROW     = 112
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] red_seq,
    input  logic [NUM_SLOTS-1:0] yellow_seq,
    input  logic                 hit,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SW-1:0] c_last_slot = SW'(NUM_SLOTS - 1);

    // Reject geometries that would draw off screen or break the counters
    generate
        if ((X_ORIGIN + (NUM_SLOTS - 1) * X_PITCH + SQ_SIZE - 1 > c_vga_width - 1) ||
            (Y_ROW + SQ_SIZE - 1 > c_vga_height - 1) ||
            (SQ_SIZE < 2) || (SQ_SIZE > 8) || ((SQ_SIZE & (SQ_SIZE - 1)) != 0) ||
            (X_PITCH < SQ_SIZE) || (NUM_SLOTS < 2)) begin : g_param_check
            $error("note_lane_renderer: lane geometry does not fit the 160x120 screen");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_SLOTS-1:0] r_red;
    logic [NUM_SLOTS-1:0] r_yellow;
    logic                 r_hit;
    logic [SW-1:0]        r_slot;
    logic                 r_last_sent;
    logic [CW-1:0]        w_px;
    logic [CW-1:0]        w_py;
    logic                 w_sq_last;
    logic                 w_accept;
    logic                 w_emit;
    logic                 w_finish;
    logic                 w_frame_last;
    logic                 w_src_red;
    logic                 w_src_yellow;
    logic                 w_src_hit;
    logic [2:0]           w_colour;
    logic [7:0]           w_x;
    logic [6:0]           w_y;

    // The counters always point at the pixel to be loaded into the output
    // registers at the next edge; clearing them whenever nothing is emitted
    // keeps them parked at slot 0 / pixel 0 between frames.
    note_lane_renderer_square_scan #(
        .SQ_SIZE (SQ_SIZE)
    ) u_square_scan (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (w_emit),
        .clear      (!w_emit),
        .px         (w_px),
        .py         (w_py),
        .last_pixel (w_sq_last)
    );

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and per-cycle strobes: emit a pixel, or close the frame
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_emit      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_emit      = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_last_sent) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_emit = 1'b1;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_frame_last = w_sq_last && (r_slot == c_last_slot);

    // Slot counter and last-pixel marker
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slot      <= '0;
            r_last_sent <= 1'b0;
        end else begin
            r_last_sent <= w_emit && w_frame_last;
            if (!w_emit)
                r_slot <= '0;
            else if (w_sq_last)
                r_slot <= (r_slot == c_last_slot) ? '0 : r_slot + SW'(1);
        end
    end

    // Lane snapshot taken when a frame is accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_red    <= '0;
            r_yellow <= '0;
            r_hit    <= 1'b0;
        end else if (w_accept) begin
            r_red    <= red_seq;
            r_yellow <= yellow_seq;
            r_hit    <= hit;
        end
    end

    // The first pixel is loaded in the same edge that takes the snapshot,
    // so in IDLE the live inputs stand in for the not-yet-written snapshot.
    always_comb begin
        w_src_red    = r_red[r_slot];
        w_src_yellow = r_yellow[r_slot];
        w_src_hit    = r_hit;
        if (r_state == ST_IDLE) begin
            w_src_red    = red_seq[r_slot];
            w_src_yellow = yellow_seq[r_slot];
            w_src_hit    = hit;
        end
    end

    assign w_colour = pick_colour(w_src_red, w_src_yellow,
                                  w_src_hit && (r_slot == '0));
    assign w_x = 8'(X_ORIGIN + int'(r_slot) * X_PITCH + int'(w_px));
    assign w_y = 7'(Y_ROW + int'(w_py));

    // Registered VGA outputs and handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= c_col_black;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= w_finish;
            if (w_emit) begin
                x      <= w_x;
                y      <= w_y;
                colour <= w_colour;
                plot   <= 1'b1;
                busy   <= 1'b1;
            end else if (w_finish) begin
                plot <= 1'b0;
                busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_lane_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_lane_renderer
// Brief    : Directed self-checking bench for note_lane_renderer, default
//            lane plus a 4-slot / 8x8 variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_lane_renderer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;

    logic       start = 1'b0;
    logic [9:0] red_seq = '0;
    logic [9:0] yellow_seq = '0;
    logic       hit = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    logic       b_start = 1'b0;
    logic [3:0] b_red_seq = '0;
    logic [3:0] b_yellow_seq = '0;
    logic       b_hit = 1'b0;
    logic [7:0] b_x;
    logic [6:0] b_y;
    logic [2:0] b_colour;
    logic       b_plot, b_busy, b_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    note_lane_renderer u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .red_seq    (red_seq),
        .yellow_seq (yellow_seq),
        .hit        (hit),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    note_lane_renderer #(
        .NUM_SLOTS (4),
        .SQ_SIZE   (8),
        .X_ORIGIN  (10),
        .X_PITCH   (16),
        .Y_ROW     (112)
    ) u_dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .start      (b_start),
        .red_seq    (b_red_seq),
        .yellow_seq (b_yellow_seq),
        .hit        (b_hit),
        .x          (b_x),
        .y          (b_y),
        .colour     (b_colour),
        .plot       (b_plot),
        .busy       (b_busy),
        .done       (b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    // Colour a slot must get: hit highlight, then red, then yellow, else black
    function automatic logic [2:0] exp_col(input int s, input logic r, input logic yl, input logic h);
        if (h && s == 0 && (r || yl)) return 3'b010;
        if (r)                        return 3'b100;
        if (yl)                       return 3'b110;
        return 3'b000;
    endfunction

    // One default-lane frame. poke: disturb start/inputs at pixel 50.
    // b2b: 0 none, 1 start pulse only in done cycle, 2 start held into IDLE.
    task automatic run_frame(input string tag, input logic [9:0] rs, input logic [9:0] ys,
                             input logic hv, input bit poke, input int b2b);
        int plots;
        int extra;
        plots = 0;
        @(negedge clk);
        red_seq = rs; yellow_seq = ys; hit = hv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 160; k++) begin
            int s, px, py;
            s  = k / 16;
            py = (k % 16) / 4;
            px = k % 4;
            plots += int'(plot);
            check($sformatf("%s pix%0d", tag, k),
                  {11'd0, plot, busy, done, colour, x, y},
                  {11'd0, 1'b1, 1'b1, 1'b0, exp_col(s, rs[s], ys[s], hv),
                   8'(10 + s * 10 + px), 7'(112 + py)});
            if (poke && k == 50) begin
                start = 1'b1; red_seq = ~rs; yellow_seq = ~ys; hit = ~hv;
            end
            if (poke && k == 51) start = 1'b0;
            @(negedge clk);
        end
        check({tag, " plots"}, plots, 160);
        check({tag, " done"}, {plot, busy, done}, 3'b001);
        red_seq = '0; yellow_seq = '0; hit = 1'b0;
        if (b2b != 0) start = 1'b1;
        @(negedge clk);
        check({tag, " idle"}, {plot, busy, done}, 3'b000);
        if (b2b == 1) begin
            start = 1'b0;
            extra = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                extra += int'(plot) + int'(done);
            end
            check({tag, " pulse in done ignored"}, extra, 0);
        end else if (b2b == 2) begin
            @(negedge clk);
            start = 1'b0;
            check({tag, " b2b first"}, {plot, busy, x, y}, {1'b1, 1'b1, 8'd10, 7'd112});
            extra = 0;
            for (int k = 0; k < 400 && extra == 0; k++) begin
                @(negedge clk);
                if (done) extra = 1;
            end
            check({tag, " b2b done"}, extra, 1);
            @(negedge clk);
        end else if (poke) begin
            extra = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                extra += int'(plot) + int'(done);
            end
            check({tag, " no restart"}, extra, 0);
        end
    endtask

    initial begin
        int cnt;
        int dones;
        repeat (3) @(negedge clk);
        check("reset a", {x, y, colour, plot, busy, done}, '0);
        check("reset b", {b_x, b_y, b_colour, b_plot, b_busy, b_done}, '0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle no plot", {plot, busy, done}, 3'b000);

        run_frame("t1 red0",       10'h001, 10'h000, 1'b0, 1'b0, 0);
        run_frame("t2 red9 prio",  10'h200, 10'h200, 1'b0, 1'b0, 0);
        run_frame("t3 hit",        10'h000, 10'h003, 1'b1, 1'b0, 1);
        run_frame("t4 poke",       10'h0F0, 10'h30F, 1'b0, 1'b1, 0);
        run_frame("t7 hit red",    10'h155, 10'h2AA, 1'b1, 1'b0, 2);

        // Reset in the middle of a frame
        @(negedge clk);
        red_seq = 10'h3FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (70) @(negedge clk);
        check("t5 plotting at 70", {plot, busy}, 2'b11);
        resetn = 1'b0;
        #1;
        check("t5 async drop", {plot, busy, done}, 3'b000);
        @(negedge clk);
        resetn = 1'b1;
        cnt = 0; dones = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            cnt += int'(plot);
            dones += int'(done);
        end
        check("t5 no plots after reset", cnt, 0);
        check("t5 no done after reset", dones, 0);
        run_frame("t5 after reset", 10'h000, 10'h3FF, 1'b0, 1'b0, 0);

        // 4 slots of 8x8 squares, pitch 16
        @(negedge clk);
        b_red_seq = 4'b0101; b_yellow_seq = 4'b0010; b_hit = 1'b1; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            int s, px, py;
            s  = k / 64;
            py = (k % 64) / 8;
            px = k % 8;
            cnt += int'(b_plot);
            check($sformatf("t6 pix%0d", k),
                  {11'd0, b_plot, b_busy, b_done, b_colour, b_x, b_y},
                  {11'd0, 1'b1, 1'b1, 1'b0, exp_col(s, b_red_seq[s], b_yellow_seq[s], b_hit),
                   8'(10 + s * 16 + px), 7'(112 + py)});
            if (k == 255) check("t6 last xy", {b_x, b_y}, {8'd65, 7'd119});
            @(negedge clk);
        end
        check("t6 plots", cnt, 256);
        check("t6 done", {b_plot, b_busy, b_done}, 3'b001);
        @(negedge clk);
        check("t6 done width", {b_plot, b_busy, b_done}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
